// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with a manual channel select and an auto-scan
// sequencer that holds each channel for DWELL cycles.
module mux_scan_n #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DWELL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                En,
    input  logic                Mode,
    input  logic [SEL_W-1:0]    Sel,
    input  logic [N_CH*W-1:0]   A,
    output logic [W-1:0]        F,
    output logic [SEL_W-1:0]    Ch,
    output logic                Valid,
    output logic                Wrap,
    output logic                Err
);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    localparam logic [SEL_W:0]   NCH_EXT  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);
    localparam logic [15:0]      LAST_CNT = 16'(DWELL - 1);

    state_t            state;
    state_t            next_state;
    logic [SEL_W-1:0]  idx;
    logic [15:0]       cnt;

    logic [SEL_W-1:0]  pos_idx;
    logic [15:0]       pos_cnt;
    logic              sel_oob;

    logic [W-1:0]      f_n;
    logic [SEL_W-1:0]  ch_n;
    logic              valid_n;
    logic              wrap_n;
    logic              err_n;
    logic [SEL_W-1:0]  idx_n;
    logic [15:0]       cnt_n;

    function automatic logic [W-1:0] pick(input logic [SEL_W-1:0] i);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i == SEL_W'(k)) begin
                v = A[k*W +: W];
            end
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!En) begin
            next_state = IDLE;
        end else if (Mode) begin
            next_state = SCAN;
        end else begin
            next_state = MANUAL;
        end
    end

    assign sel_oob = ({1'b0, Sel} >= NCH_EXT);

    // idx/cnt name the scan position currently on the outputs; only a cycle
    // already in SCAN advances it, so resuming from IDLE re-shows the frozen one.
    always_comb begin
        pos_idx = idx;
        pos_cnt = cnt;
        if (state == SCAN) begin
            if (cnt == LAST_CNT) begin
                pos_cnt = '0;
                pos_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                pos_cnt = cnt + 16'd1;
            end
        end

        f_n     = F;
        ch_n    = Ch;
        err_n   = Err;
        valid_n = 1'b0;
        wrap_n  = 1'b0;
        idx_n   = idx;
        cnt_n   = cnt;

        case (next_state)
            MANUAL: begin
                f_n     = sel_oob ? '0 : pick(Sel);
                ch_n    = Sel;
                err_n   = sel_oob;
                valid_n = 1'b1;
                idx_n   = '0;
                cnt_n   = '0;
            end
            SCAN: begin
                f_n     = pick(pos_idx);
                ch_n    = pos_idx;
                err_n   = 1'b0;
                valid_n = 1'b1;
                wrap_n  = (pos_idx == LAST_IDX) && (pos_cnt == LAST_CNT);
                idx_n   = pos_idx;
                cnt_n   = pos_cnt;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F     <= '0;
            Ch    <= '0;
            Valid <= 1'b0;
            Wrap  <= 1'b0;
            Err   <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            F     <= f_n;
            Ch    <= ch_n;
            Valid <= valid_n;
            Wrap  <= wrap_n;
            Err   <= err_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: three parameterisations run in lockstep against a
// position-counter reference model, plus directed corner-case sequences.
module tb_mux_scan_n;

    logic        clk;
    logic        rst_n;
    logic        En;
    logic        Mode;

    logic [2:0]  sel8;
    logic [31:0] a8;
    logic [3:0]  F8;
    logic [2:0]  Ch8;
    logic        Valid8, Wrap8, Err8;

    logic [1:0]  sel4;
    logic [31:0] a4;
    logic [7:0]  F4;
    logic [1:0]  Ch4;
    logic        Valid4, Wrap4, Err4;

    logic [2:0]  sel5;
    logic [19:0] a5;
    logic [3:0]  F5;
    logic [2:0]  Ch5;
    logic        Valid5, Wrap5, Err5;

    int checks;
    int passes;

    mux_scan_n #(.N_CH(8), .W(4), .DWELL(2)) u8 (
        .clk(clk), .rst_n(rst_n), .En(En), .Mode(Mode), .Sel(sel8), .A(a8),
        .F(F8), .Ch(Ch8), .Valid(Valid8), .Wrap(Wrap8), .Err(Err8)
    );

    mux_scan_n #(.N_CH(4), .W(8), .DWELL(3)) u4 (
        .clk(clk), .rst_n(rst_n), .En(En), .Mode(Mode), .Sel(sel4), .A(a4),
        .F(F4), .Ch(Ch4), .Valid(Valid4), .Wrap(Wrap4), .Err(Err4)
    );

    mux_scan_n #(.N_CH(5), .W(4), .DWELL(1)) u5 (
        .clk(clk), .rst_n(rst_n), .En(En), .Mode(Mode), .Sel(sel5), .A(a5),
        .F(F5), .Ch(Ch5), .Valid(Valid5), .Wrap(Wrap5), .Err(Err5)
    );

    always #5 clk = ~clk;

    // Scan progress is one linear position p over N_CH*DWELL ticks; ph is 0 idle, 1 manual, 2 scan.
    typedef struct {
        int ph;
        int p;
        int f;
        int ch;
        int valid;
        int wrap;
        int err;
    } mdl_t;

    mdl_t m8, m4, m5;

    typedef struct {
        int ch;
        int f;
        int wrap;
    } vec_t;

    vec_t vecs[14];

    function automatic int chan(logic [63:0] a, int k, int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return int'((a >> (k * w)) & mask);
    endfunction

    function automatic mdl_t mstep(mdl_t m, int nch, int w, int dwell,
                                   logic rstn, logic en, logic mode, int sel, logic [63:0] a);
        mdl_t r;
        int   nph;
        r = m;
        r.valid = 0;
        r.wrap  = 0;
        if (!rstn) begin
            r = '{default: 0};
            return r;
        end
        nph = !en ? 0 : (mode ? 2 : 1);
        if (nph == 1) begin
            r.p     = 0;
            r.ch    = sel;
            r.err   = (sel >= nch) ? 1 : 0;
            r.f     = r.err ? 0 : chan(a, sel, w);
            r.valid = 1;
        end else if (nph == 2) begin
            if (m.ph == 2) begin
                r.p = (m.p + 1) % (nch * dwell);
            end else if (m.ph == 1) begin
                r.p = 0;
            end
            r.ch    = r.p / dwell;
            r.f     = chan(a, r.ch, w);
            r.err   = 0;
            r.valid = 1;
            r.wrap  = (r.p == nch * dwell - 1) ? 1 : 0;
        end
        r.ph = nph;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModels();
        checkOutput("u8.F",     int'(F8),     m8.f);
        checkOutput("u8.Ch",    int'(Ch8),    m8.ch);
        checkOutput("u8.Valid", int'(Valid8), m8.valid);
        checkOutput("u8.Wrap",  int'(Wrap8),  m8.wrap);
        checkOutput("u8.Err",   int'(Err8),   m8.err);
        checkOutput("u4.F",     int'(F4),     m4.f);
        checkOutput("u4.Ch",    int'(Ch4),    m4.ch);
        checkOutput("u4.Valid", int'(Valid4), m4.valid);
        checkOutput("u4.Wrap",  int'(Wrap4),  m4.wrap);
        checkOutput("u4.Err",   int'(Err4),   m4.err);
        checkOutput("u5.F",     int'(F5),     m5.f);
        checkOutput("u5.Ch",    int'(Ch5),    m5.ch);
        checkOutput("u5.Valid", int'(Valid5), m5.valid);
        checkOutput("u5.Wrap",  int'(Wrap5),  m5.wrap);
        checkOutput("u5.Err",   int'(Err5),   m5.err);
    endtask

    // Inputs change 1 time unit after an edge, so the models see exactly what the DUTs sampled.
    task automatic applyStimulus(input logic r, input logic e, input logic md);
        rst_n = r;
        En    = e;
        Mode  = md;
        @(posedge clk);
        m8 = mstep(m8, 8, 4, 2, r, e, md, int'(sel8), 64'(a8));
        m4 = mstep(m4, 4, 8, 3, r, e, md, int'(sel4), 64'(a4));
        m5 = mstep(m5, 5, 4, 1, r, e, md, int'(sel5), 64'(a5));
        #1;
        checkModels();
    endtask

    initial begin
        int fb[4];
        logic md;

        clk = 1'b0;
        rst_n = 1'b0;
        En = 1'b0;
        Mode = 1'b0;
        sel8 = '0;
        sel4 = '0;
        sel5 = '0;
        a8 = 32'h9E3A_5C17;
        a4 = 32'hD3C2_B1A0;
        a5 = 20'hABCDE;
        checks = 0;
        passes = 0;
        m8 = '{default: 0};
        m4 = '{default: 0};
        m5 = '{default: 0};

        fb = '{'hA0, 'hB1, 'hC2, 'hD3};
        for (int i = 0; i < 14; i++) begin
            vecs[i] = '{(i / 3) % 4, fb[(i / 3) % 4], (i % 12 == 11) ? 1 : 0};
        end

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset F",     int'(F8),     0);
        checkOutput("reset Ch",    int'(Ch8),    0);
        checkOutput("reset Valid", int'(Valid8), 0);
        checkOutput("reset Wrap",  int'(Wrap4),  0);
        checkOutput("reset Err",   int'(Err5),   0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("dwell Ch",    int'(Ch4),    vecs[i].ch);
            checkOutput("dwell F",     int'(F4),     vecs[i].f);
            checkOutput("dwell Wrap",  int'(Wrap4),  vecs[i].wrap);
            checkOutput("dwell Valid", int'(Valid4), 1);
        end

        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midscan reset F",     int'(F8),     0);
        checkOutput("midscan reset Ch",    int'(Ch8),    0);
        checkOutput("midscan reset Valid", int'(Valid8), 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("restart Ch",    int'(Ch8),    0);
        checkOutput("restart Valid", int'(Valid8), 1);

        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("pre-freeze Ch", int'(Ch8), 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("freeze Valid", int'(Valid8), 0);
            checkOutput("freeze Ch",    int'(Ch8),    3);
            checkOutput("freeze F",     int'(F8),     chan(64'(a8), 3, 4));
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("resume Ch",    int'(Ch8),    3);
        checkOutput("resume Valid", int'(Valid8), 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("resume next Ch", int'(Ch8), 4);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("pre-wrap Ch",   int'(Ch8),   7);
        checkOutput("pre-wrap Wrap", int'(Wrap8), 0);
        sel8 = 3'd2;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("switch Wrap", int'(Wrap8), 0);
        checkOutput("switch Ch",   int'(Ch8),   2);
        checkOutput("switch F",    int'(F8),    'hC);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rescan Ch", int'(Ch8), 0);
        checkOutput("rescan F",  int'(F8),  'h7);

        sel5 = 3'd6;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("oob F",     int'(F5),     0);
        checkOutput("oob Err",   int'(Err5),   1);
        checkOutput("oob Valid", int'(Valid5), 1);
        checkOutput("oob Ch",    int'(Ch5),    6);
        sel5 = 3'd4;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sel4 F",   int'(F5),   'hA);
        checkOutput("sel4 Err", int'(Err5), 0);

        md = 1'b1;
        for (int i = 0; i < 600; i++) begin
            sel8 = 3'($urandom_range(0, 7));
            sel4 = 2'($urandom_range(0, 3));
            sel5 = 3'($urandom_range(0, 7));
            a8 = $urandom;
            a4 = $urandom;
            a5 = 20'($urandom);
            if ($urandom_range(0, 9) == 0) md = ~md;
            applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 7) != 0, md);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
Parametrised, registered N:1 multiplexer with a W-bit data path. It has two modes. In manual mode the external Sel port picks the channel. In scan mode an internal sequencer steps through every channel, holding each one for a programmable dwell time. The block sits between a bank of channel sources and a single serial consumer, for example a display/probe bus or a shared ADC-style sink.

Parameters:
N_CH, 8, number of input channels (2..256; non-power-of-2 allowed)
W, 1, data width per channel in bits
SEL_W, $clog2(N_CH), width of Sel/Ch fields (derived, do not override)
DWELL, 1, cycles each channel is held in scan mode (1..65535)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
En  in  1  global enable; 0 freezes the block
Mode  in  1  0 = manual select, 1 = auto scan
Sel  in  SEL_W  channel index used in manual mode
A  in  N_CH*W  packed inputs; channel k = A[k*W +: W]
F  out  W  registered selected data
Ch  out  SEL_W  index of the channel currently driving F
Valid  out  1  F/Ch hold a fresh sample this cycle
Wrap  out  1  one-cycle pulse on the last dwell cycle of channel N_CH-1 (scan only)
Err  out  1  registered flag: manual Sel >= N_CH

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; no asynchronous paths.
- Reset (rst_n=0 at a clk edge):
  - F=0, Ch=0, Valid=0, Wrap=0, Err=0.
  - Dwell counter=0, scan index=0, FSM=IDLE.
  - Reset asserted mid-scan aborts the sweep. After release, scan restarts at channel 0.
- FSM states: IDLE, MANUAL, SCAN.
  - Any state with En=0 goes to IDLE.
  - IDLE with En=1 goes to MANUAL (Mode=0) or SCAN (Mode=1).
  - MANUAL with Mode=1 goes to SCAN; SCAN with Mode=0 goes to MANUAL.
  - Transitions are evaluated each edge. The state's outputs first appear on the edge the state is entered.
- IDLE:
  - F, Ch and Err hold their last values.
  - Valid=0, Wrap=0.
  - Scan index and dwell counter are frozen (not cleared).
- MANUAL:
  - Latency is exactly 1 cycle: F(t+1)=A[Sel(t)], Ch(t+1)=Sel(t), Valid=1, Wrap=0.
  - Sel >= N_CH (only possible when N_CH is not a power of 2) gives F=0, Ch=Sel, Err=1, Valid=1.
  - Otherwise Err=0.
- SCAN:
  - Entry from MANUAL or from IDLE-after-reset: scan index=0, dwell counter=0.
  - Re-entry from IDLE after En dropped (no reset in between): resume at the frozen index and counter.
  - Each active cycle: F=A[index] (registered, 1 cycle after the index value), Ch=index, Valid=1, Err=0.
  - Dwell counter increments each cycle. When it reaches DWELL-1 it clears and the index advances.
  - The index wraps from N_CH-1 to 0.
  - Wrap=1 on exactly the cycle where index=N_CH-1 and counter=DWELL-1 are being output.
  - DWELL=1 means the index advances every cycle.
- A changing while selected: F follows with 1-cycle latency; no hold or sample-lock.
- Simultaneous events:
  - rst_n=0 overrides everything.
  - En=0 overrides Mode.
  - A Mode change and a scan wrap on the same edge: the mode change wins and Wrap is not asserted.
- Width rules:
  - Dwell counter is 16 bits.
  - Index comparison uses SEL_W bits; no out-of-range index is ever produced in scan mode.

Test Plan:
- Reset mid-scan: N_CH=8, W=1, DWELL=1, Mode=1, En=1, rst_n pulled low at index 5 -> next edge: F=0, Ch=0, Valid=0. One cycle after release: Ch=0, Valid=1.
- Manual exhaustive (N_CH=8, W=1): En=1, Mode=0, sweep Sel 0..7 and A 0..255 -> every cycle F(t+1)=A(t)[Sel(t)], Ch(t+1)=Sel(t), Err=0.
- Scan dwell: N_CH=4, W=8, DWELL=3, A={8'hD3,8'hC2,8'hB1,8'hA0} -> Ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0..., F=A0,A0,A0,B1,..., Wrap high only on the third cycle of Ch=3.
- Non-power-of-2: N_CH=5, Mode=0, Sel=6 -> F=0, Err=1, Valid=1. Then Sel=4 -> F=A[4], Err=0.
- En freeze/resume: N_CH=8, DWELL=2, Mode=1, En dropped for 4 cycles at index 3, counter 1 -> Valid=0 and F/Ch held during the freeze. On En=1: Ch=3 for one cycle, then Ch=4.
- Mode switch on wrap edge: N_CH=8, Mode 1->0 on the edge where Wrap would fire, Sel=2 -> Wrap stays 0, next output Ch=2, F=A[2]. Returning to Mode=1 restarts scan at Ch=0.
